// File: rtl/mem_bist_initiator.sv
// rtl/mem_bist_initiator.sv - write/readback BIST traffic source for a 2^ADDR_W x DATA_W memory
// Writes seed ^ replicated-address to every word, reads each back and records errors/timeouts.
module mem_bist_initiator #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  output logic              en,
  output logic [DATA_W-1:0] data_in,
  output logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_out,
  input  logic              valid_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic              timeout_seen
);

  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [ADDR_W:0] ERR_MAX = (ADDR_W+1)'(1 << ADDR_W);

  typedef enum logic [2:0] {IDLE, WRITE, RD_REQ, RD_WAIT, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] seed_q;
  logic [ADDR_W-1:0] addr_cnt;
  logic [WW-1:0]     wait_cnt;
  logic              last_addr;
  logic              rd_timeout;
  logic              rd_fail;
  logic              rd_done;

  // Address bits are tiled across the word, wrapping when DATA_W is not a multiple of ADDR_W.
  function automatic logic [DATA_W-1:0] pattern(input logic [DATA_W-1:0] s,
                                                input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = a[i % ADDR_W];
    return s ^ r;
  endfunction

  always_comb begin
    last_addr  = (addr_cnt == {ADDR_W{1'b1}});
    rd_timeout = !valid_out && (wait_cnt == WW'(TIMEOUT - 1));
    rd_fail    = valid_out ? (data_out != pattern(seed_q, addr_cnt)) : rd_timeout;
    rd_done    = valid_out || rd_timeout;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      seed_q          <= '0;
      addr_cnt        <= '0;
      wait_cnt        <= '0;
      en              <= 1'b0;
      data_in         <= '0;
      address         <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_fail_addr <= '0;
      timeout_seen    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            seed_q          <= seed;
            err_count       <= '0;
            first_fail_addr <= '0;
            timeout_seen    <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            addr_cnt        <= '0;
            busy            <= 1'b1;
            en              <= 1'b1;
            address         <= '0;
            data_in         <= pattern(seed, '0);
            state           <= WRITE;
          end
        end
        WRITE: begin
          if (last_addr) begin
            addr_cnt <= '0;
            en       <= 1'b0;
            address  <= '0;
            data_in  <= '0;
            wait_cnt <= '0;
            state    <= RD_REQ;
          end else begin
            addr_cnt <= addr_cnt + ADDR_W'(1);
            address  <= addr_cnt + ADDR_W'(1);
            data_in  <= pattern(seed_q, addr_cnt + ADDR_W'(1));
          end
        end
        RD_REQ: begin
          wait_cnt <= '0;
          state    <= RD_WAIT;
        end
        RD_WAIT: begin
          if (rd_done) begin
            if (rd_fail) begin
              if (err_count != ERR_MAX) err_count <= err_count + (ADDR_W+1)'(1);
              if (err_count == '0) first_fail_addr <= addr_cnt;
            end
            if (rd_timeout) timeout_seen <= 1'b1;
            if (last_addr) begin
              // err_count has not absorbed this read yet, so fold it in here.
              pass    <= (err_count == '0) && !rd_fail;
              busy    <= 1'b0;
              done    <= 1'b1;
              address <= '0;
              state   <= DONE;
            end else begin
              addr_cnt <= addr_cnt + ADDR_W'(1);
              address  <= addr_cnt + ADDR_W'(1);
              state    <= RD_REQ;
            end
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bist_initiator.sv
// tb/tb_mem_bist_initiator.sv - randomized self-checking bench for mem_bist_initiator
// A behavioural memory responder with injectable faults drives the DUT; each sweep is predicted from the pattern rule.
module tb_mem_bist_initiator;

  localparam int TIMEOUT = 8;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] seed;
  logic        en;
  logic [31:0] data_in;
  logic [3:0]  address;
  logic [31:0] data_out;
  logic        valid_out;
  logic        busy;
  logic        done;
  logic        pass;
  logic [4:0]  err_count;
  logic [3:0]  first_fail_addr;
  logic        timeout_seen;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] mem     [16];
  logic [31:0] corrupt [16];
  bit          drop    [16];
  bit          stuck;
  bit          spurious;
  logic [3:0]  waddr [$];
  logic [31:0] wdata [$];

  mem_bist_initiator #(.DATA_W(32), .ADDR_W(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed),
    .en(en), .data_in(data_in), .address(address),
    .data_out(data_out), .valid_out(valid_out),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail_addr(first_fail_addr), .timeout_seen(timeout_seen)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory responder: samples requests mid-cycle, answers reads one cycle later.
  always @(negedge clk) begin
    if (en) begin
      mem[address] = data_in;
      if (busy) begin
        waddr.push_back(address);
        wdata.push_back(data_in);
      end
      valid_out = spurious;
      data_out  = spurious ? $urandom : 32'h0;
    end else begin
      valid_out = !drop[address];
      data_out  = stuck ? 32'h0 : (mem[address] ^ corrupt[address]);
    end
  end

  task automatic clear_faults();
    for (int a = 0; a < 16; a++) begin
      corrupt[a] = 32'h0;
      drop[a]    = 1'b0;
    end
    stuck    = 1'b0;
    spurious = 1'b0;
  endtask

  task automatic run_sweep(input string name, input logic [31:0] s, input bit mid_start);
    logic [31:0] e;
    logic [31:0] obs;
    int exp_err, exp_first, ndrop, cycles, exp_cycles;
    bit exp_to;
    exp_err = 0; exp_first = 0; ndrop = 0; exp_to = 0;
    for (int a = 0; a < 16; a++) begin
      e   = s ^ (a * 32'h1111_1111);
      obs = stuck ? 32'h0 : (e ^ corrupt[a]);
      if (drop[a] || obs != e) begin
        if (exp_err == 0) exp_first = a;
        exp_err++;
      end
      if (drop[a]) begin
        exp_to = 1'b1;
        ndrop++;
      end
    end
    exp_cycles = 16 + 2 * 16 + ndrop * (TIMEOUT - 1);
    waddr.delete();
    wdata.delete();

    @(negedge clk); seed = s; start = 1'b1;
    @(negedge clk); start = 1'b0; seed = $urandom;
    n_cmp++;
    if ({busy, done, err_count, timeout_seen} !== {1'b1, 1'b0, 5'd0, 1'b0}) begin
      $display("FAIL %s start_clear: got busy/done/err/to=%0b/%0b/%0d/%0b expected 1/0/0/0",
               name, busy, done, err_count, timeout_seen);
      n_fail++;
    end
    cycles = 0;
    while (!done && cycles < 600) begin
      @(negedge clk);
      cycles++;
      start = mid_start && (cycles == 20);
      if (start) seed = $urandom;
    end
    start = 1'b0;

    n_cmp++;
    if (cycles !== exp_cycles) begin
      $display("FAIL %s sweep_cycles: got %0d expected %0d", name, cycles, exp_cycles);
      n_fail++;
    end
    n_cmp++;
    if ({done, busy, pass} !== {1'b1, 1'b0, exp_err == 0}) begin
      $display("FAIL %s done_busy_pass: got %0b%0b%0b expected 10%0b", name, done, busy, pass, exp_err == 0);
      n_fail++;
    end
    n_cmp++;
    if (err_count !== 5'(exp_err)) begin
      $display("FAIL %s err_count: got %0d expected %0d", name, err_count, exp_err);
      n_fail++;
    end
    n_cmp++;
    if (first_fail_addr !== 4'(exp_first)) begin
      $display("FAIL %s first_fail_addr: got %0d expected %0d", name, first_fail_addr, exp_first);
      n_fail++;
    end
    n_cmp++;
    if (timeout_seen !== exp_to) begin
      $display("FAIL %s timeout_seen: got %0b expected %0b", name, timeout_seen, exp_to);
      n_fail++;
    end
    n_cmp++;
    if ({en, address} !== 5'h0) begin
      $display("FAIL %s done_idle_bus: got en=%0b addr=%0d expected 0/0", name, en, address);
      n_fail++;
    end
    n_cmp++;
    if (waddr.size() != 16) begin
      $display("FAIL %s write_count: got %0d expected 16", name, waddr.size());
      n_fail++;
    end else begin
      for (int a = 0; a < 16; a++) begin
        e = s ^ (a * 32'h1111_1111);
        n_cmp++;
        if (waddr[a] !== 4'(a) || wdata[a] !== e) begin
          $display("FAIL %s write[%0d]: got addr=%0d data=%08h expected addr=%0d data=%08h",
                   name, a, waddr[a], wdata[a], a, e);
          n_fail++;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; seed = 32'h0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({en, data_in, address, busy, done, pass, err_count, first_fail_addr, timeout_seen} !== '0) begin
      $display("FAIL reset_state: got en=%0b data=%08h addr=%0d busy=%0b done=%0b pass=%0b err=%0d ffa=%0d to=%0b expected all 0",
               en, data_in, address, busy, done, pass, err_count, first_fail_addr, timeout_seen);
      n_fail++;
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_good();
    clear_faults();
    run_sweep("good", 32'hA5A5_0000, 1'b0);
  endtask

  task automatic test_corrupt();
    clear_faults();
    corrupt[5] = 32'h1;
    corrupt[9] = 32'h8000_0400;
    run_sweep("corrupt", 32'hA5A5_0000, 1'b0);
  endtask

  task automatic test_timeout();
    clear_faults();
    drop[7] = 1'b1;
    run_sweep("timeout", $urandom, 1'b0);
  endtask

  task automatic test_spurious();
    clear_faults();
    spurious = 1'b1;
    run_sweep("spurious_midstart", $urandom, 1'b1);
  endtask

  task automatic test_stuck();
    clear_faults();
    stuck = 1'b1;
    run_sweep("stuck_zero", 32'h0, 1'b0);
  endtask

  task automatic test_back_to_back();
    clear_faults();
    corrupt[15] = 32'h0000_0100;
    run_sweep("b2b_first", $urandom, 1'b0);
    clear_faults();
    run_sweep("b2b_second", $urandom, 1'b0);
  endtask

  task automatic test_reset_mid();
    int k;
    clear_faults();
    corrupt[1] = 32'h4;
    @(negedge clk); seed = $urandom; start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (!(busy && !en && address == 4'd4) && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (k >= 200) begin
      $display("FAIL reset_mid reach_addr4: got no read of address 4 within %0d cycles expected one", k);
      n_fail++;
    end
    @(negedge clk);
    n_cmp++;
    if (err_count !== 5'd1) begin
      $display("FAIL reset_mid pre_err: got %0d expected 1", err_count);
      n_fail++;
    end
    #1 rst = 1'b0;
    #1;
    n_cmp++;
    if ({en, data_in, address, busy, done, pass, err_count, first_fail_addr, timeout_seen} !== '0) begin
      $display("FAIL reset_mid async_clear: got en=%0b data=%08h addr=%0d busy=%0b done=%0b err=%0d ffa=%0d expected all 0",
               en, data_in, address, busy, done, err_count, first_fail_addr);
      n_fail++;
    end
    @(negedge clk); rst = 1'b1;
    repeat (60) @(negedge clk);
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      $display("FAIL reset_mid abandoned: got busy=%0b done=%0b expected 0/0", busy, done);
      n_fail++;
    end
    clear_faults();
    run_sweep("after_reset_seed0", 32'h0, 1'b0);
  endtask

  task automatic test_random();
    int nc;
    for (int r = 0; r < 4; r++) begin
      clear_faults();
      nc = $urandom_range(0, 3);
      for (int i = 0; i < nc; i++) corrupt[$urandom_range(0, 15)] = 32'h1 << $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) drop[$urandom_range(0, 15)] = 1'b1;
      spurious = $urandom_range(0, 1) == 1;
      run_sweep("random", $urandom, $urandom_range(0, 1) == 1);
    end
  endtask

  initial begin
    clear_faults();
    valid_out = 1'b0;
    data_out  = 32'h0;
    test_reset();
    test_good();
    test_corrupt();
    test_timeout();
    test_spurious();
    test_reset_mid();
    test_stuck();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
